// File: rtl/tb_clkdiv_multi.sv
// Multi-channel divided-clock/tick generator with stretched reset output; each channel has a glitch-free shadowed half-period.
// Optional TB_CLKDIV_TICKCNT_EN adds per-channel 16-bit tick counters on tick_cnt_o.
module tb_clkdiv_multi #(
  parameter int N_CH     = 4,
  parameter int DIV_W    = 8,
  parameter int RST_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH*DIV_W-1:0]   div_i,
  input  logic                    load_i,
  output logic [N_CH-1:0]         clk_o,
  output logic [N_CH-1:0]         tick_o,
`ifdef TB_CLKDIV_TICKCNT_EN
  output logic [N_CH*16-1:0]      tick_cnt_o,
`endif
  output logic                    rst_o
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [HW-1:0]    r_hold;
  logic             r_rst;
  logic [DIV_W-1:0] r_cnt [N_CH];
  logic [DIV_W-1:0] r_h   [N_CH];
  logic [DIV_W-1:0] r_s   [N_CH];
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_clk;
  logic [N_CH-1:0]  r_tick;

  logic [DIV_W-1:0] w_div [N_CH];
  logic [N_CH-1:0]  w_run;
  logic [N_CH-1:0]  w_wrap;
  logic [N_CH-1:0]  w_idle;
  logic [N_CH-1:0]  w_copy;

  // Reset stretcher: rst_o drops on the RST_HOLD-th rising edge after reset falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_rst  <= 1'b1;
    end else if (r_rst) begin
      if (r_hold == HW'(RST_HOLD - 1)) begin
        r_rst <= 1'b0;
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  // A channel keeps running while enabled, or while it still has a high phase to finish.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_div[c]  = div_i[c*DIV_W +: DIV_W];
      w_run[c]  = !r_rst && (en_i[c] || r_clk[c]);
      w_wrap[c] = w_run[c] && (r_cnt[c] == r_h[c]);
      w_idle[c] = !r_clk[c] && (!en_i[c] || r_rst);
      w_copy[c] = r_pend[c] && ((w_wrap[c] && r_clk[c]) || w_idle[c]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        r_cnt[c] <= '0;
        r_h[c]   <= '0;
        r_s[c]   <= '0;
      end
      r_pend <= '0;
      r_clk  <= '0;
      r_tick <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!w_run[c]) begin
          r_cnt[c] <= '0;
        end else if (w_wrap[c]) begin
          r_cnt[c] <= '0;
          r_clk[c] <= ~r_clk[c];
        end else begin
          r_cnt[c] <= r_cnt[c] + DIV_W'(1);
        end
        r_tick[c] <= w_wrap[c] && !r_clk[c];
        // A new load overwrites the shadow even if an older one is still pending.
        if (load_i) begin
          r_s[c] <= w_div[c];
        end
        if (w_copy[c]) begin
          r_h[c] <= r_s[c];
        end
        r_pend[c] <= load_i || (r_pend[c] && !w_copy[c]);
      end
    end
  end

`ifdef TB_CLKDIV_TICKCNT_EN
  logic [15:0] r_tcnt [N_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        r_tcnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        r_tcnt[c] <= r_tcnt[c] + 16'(r_tick[c]);
      end
    end
  end

  always_comb begin
    tick_cnt_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      tick_cnt_o[c*16 +: 16] = r_tcnt[c];
    end
  end
`endif

  assign clk_o  = r_clk;
  assign tick_o = r_tick;
  assign rst_o  = r_rst;

endmodule

// File: tb/tb_tb_clkdiv_multi.sv
// Directed bench for tb_clkdiv_multi: reset stretch, divide ratios, shadow load, enable park, async reset.
module tb_tb_clkdiv_multi;

  logic        clk;
  logic        reset;
  logic [3:0]  en_i;
  logic [31:0] div_i;
  logic        load_i;
  logic [3:0]  clk_o;
  logic [3:0]  tick_o;
  logic        rst_o;
`ifdef TB_CLKDIV_TICKCNT_EN
  logic [63:0] tick_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  tb_clkdiv_multi #(.N_CH(4), .DIV_W(8), .RST_HOLD(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_i),
    .div_i      (div_i),
    .load_i     (load_i),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
`ifdef TB_CLKDIV_TICKCNT_EN
    .tick_cnt_o (tick_cnt_o),
`endif
    .rst_o      (rst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    en_i   = 4'b0000;
    div_i  = 32'h0;
    load_i = 1'b0;
    step();
    step();
    chk("reset_rst_o", 32'(rst_o), 32'd1);
    chk("reset_clk_o", 32'(clk_o), 32'd0);
    chk("reset_tick_o", 32'(tick_o), 32'd0);

    // Test 1: reset release, rst_o falls on the 4th edge
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("hold_rst_o", 32'(rst_o), (i < 4) ? 32'd1 : 32'd0);
      chk("hold_clk_o", 32'(clk_o), 32'd0);
    end

    // Test 2: ch0 divide-by-2 with default H=0
    en_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ch0_clk", 32'(clk_o[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("ch0_tick", 32'(tick_o[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    en_i = 4'b0000;
    step();
    chk("ch0_park", 32'(clk_o[0]), 32'd0);

    // Load ch1=2, ch2=3 while idle: copies on the following cycle
    div_i  = {8'd0, 8'd3, 8'd2, 8'd0};
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    step();

    // Test 3: ch1 period 6, high 3 / low 3
    en_i = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("ch1_clk", 32'(clk_o[1]),
          ((k >= 3 && k <= 5) || (k >= 9 && k <= 11) || k == 15) ? 32'd1 : 32'd0);
      chk("ch1_tick", 32'(tick_o[1]), (k == 3 || k == 9 || k == 15) ? 32'd1 : 32'd0);
    end

    // Test 4: load div=5 mid-high; high completes at 3, new H applies from the falling toggle
    div_i[15:8] = 8'd5;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    chk("ch1_load_hi", 32'(clk_o[1]), 32'd1);
    for (int k = 17; k <= 31; k++) begin
      step();
      chk("ch1_reload_clk", 32'(clk_o[1]),
          (k == 17 || (k >= 24 && k <= 29)) ? 32'd1 : 32'd0);
      chk("ch1_reload_tick", 32'(tick_o[1]), (k == 24) ? 32'd1 : 32'd0);
    end

    // Test 5: ch2 (H=3) disabled mid-high, then re-enabled
    en_i = 4'b0110;
    for (int r = 1; r <= 16; r++) begin
      step();
      chk("ch2_clk", 32'(clk_o[2]), ((r >= 4 && r <= 7) || r == 16) ? 32'd1 : 32'd0);
      chk("ch2_tick", 32'(tick_o[2]), (r == 4 || r == 16) ? 32'd1 : 32'd0);
      if (r == 5) en_i[2] = 1'b0;
      if (r == 12) en_i[2] = 1'b1;
    end

    // Test 6: async reset mid-run
    reset = 1'b1;
    #1;
    chk("arst_clk_o", 32'(clk_o), 32'd0);
    chk("arst_tick_o", 32'(tick_o), 32'd0);
    chk("arst_rst_o", 32'(rst_o), 32'd1);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("rehold_rst_o", 32'(rst_o), (i < 4) ? 32'd1 : 32'd0);
      chk("rehold_clk_o", 32'(clk_o), 32'd0);
    end
    // Half-periods were cleared, so both enabled channels restart at clk/2
    step();
    chk("post_rst_clk", 32'(clk_o), 32'b0110);
    chk("post_rst_tick", 32'(tick_o), 32'b0110);
    step();
    chk("post_rst_clk2", 32'(clk_o), 32'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
